// File: rtl/step_run_controller.sv
// step_run_controller: debounced single-step / divided free-run clock-enable sequencer with PC breakpoint halt.
module step_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_step,
  output logic [CNT_W-1:0] step_count,
  output logic             halted,
  output logic [1:0]       state
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(RUN_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, STEP = 2'b01, RUN = 2'b10, HALT = 2'b11} state_t;
  state_t state_q, state_d;
  logic [1:0] btn_sync_q, run_sync_q;
  logic btn_prev_q, db_q, db_d, db_prev_q, step_req_q, db_fire, bp_hit, run_s, btn_s;
  logic [DW-1:0] db_cnt_q, db_cnt_d, db_run;
  logic [RW-1:0] rate_q, rate_d;
  logic cpu_step_q, cpu_step_d;
  logic [CNT_W-1:0] step_count_q;
  assign btn_s  = btn_sync_q[1];
  assign run_s  = run_sync_q[1];
  assign bp_hit = bp_en && (pc == bp_addr);
  // Count consecutive cycles the stable synced button disagrees with the debounced level.
  always_comb begin
    db_run   = (btn_s != btn_prev_q) ? '0 : db_cnt_q;
    db_fire  = (btn_s != db_q) && (db_run == DB_LAST);
    db_cnt_d = (btn_s != db_q && !db_fire) ? db_run + DW'(1) : '0;
    db_d     = db_fire ? btn_s : db_q;
  end
  always_comb begin
    state_d    = state_q;
    cpu_step_d = 1'b0;
    rate_d     = '0;
    case (state_q)
      IDLE: begin
        if (run_s) state_d = RUN;
        else if (step_req_q) begin
          state_d    = STEP;
          cpu_step_d = 1'b1;
        end
      end
      STEP: state_d = run_s ? RUN : IDLE;
      RUN: begin
        if (!run_s) state_d = IDLE;
        else if (rate_q == RATE_LAST) begin
          state_d    = bp_hit ? HALT : RUN;
          cpu_step_d = !bp_hit;
        end else rate_d = rate_q + RW'(1);
      end
      HALT: begin
        if (step_req_q) begin
          state_d    = STEP;
          cpu_step_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync_q   <= '0;
      run_sync_q   <= '0;
      btn_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
      db_q         <= 1'b0;
      db_prev_q    <= 1'b0;
      step_req_q   <= 1'b0;
      rate_q       <= '0;
      state_q      <= IDLE;
      cpu_step_q   <= 1'b0;
      step_count_q <= '0;
    end else begin
      btn_sync_q   <= {btn_sync_q[0], step_btn};
      run_sync_q   <= {run_sync_q[0], run_sw};
      btn_prev_q   <= btn_s;
      db_cnt_q     <= db_cnt_d;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      step_req_q   <= db_q & ~db_prev_q;
      rate_q       <= rate_d;
      state_q      <= state_d;
      cpu_step_q   <= cpu_step_d;
      step_count_q <= step_count_q + CNT_W'(cpu_step_q);
    end
  end
  assign cpu_step   = cpu_step_q;
  assign step_count = step_count_q;
  assign halted     = state_q == HALT;
  assign state      = state_q;
endmodule

// File: tb/tb_step_run_controller.sv
// tb_step_run_controller: scoreboard bench; expected cpu_step cycles are queued at stimulus time and matched per pulse.
module tb_step_run_controller;
  localparam int DB = 4, RD = 5, CW = 4;
  logic clk = 1'b0, reset = 1'b1, step_btn = 1'b0, run_sw = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc, npulse;
  logic cpu_step, halted;
  logic [CW-1:0] step_count;
  logic [1:0] state;
  int cyc = 0, total = 0, bad = 0;
  int exp_q[$];
  step_run_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .step_btn(step_btn), .run_sw(run_sw), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_step(cpu_step), .step_count(step_count),
    .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Processor model: pc advances by 4 on every clock-enable pulse.
  always @(posedge clk or posedge reset) npulse <= reset ? '0 : npulse + {31'b0, cpu_step};
  assign pc = npulse << 2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (cpu_step) begin
      if (exp_q.size() == 0) chk("pulse_unexp", cyc, -1);
      else chk("pulse_cyc", cyc, exp_q.pop_front());
    end
  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    chk("pending", exp_q.size(), 0);
    reset = 1'b1;
    wt(2);
    reset = 1'b0;
  endtask
  task automatic press();
    step_btn = 1'b1;
    exp_q.push_back(cyc + 8);
    wt(10);
    step_btn = 1'b0;
    wt(10);
  endtask
  initial begin
    wt(3);
    chk("rst_state", state, 0);
    chk("rst_step", cpu_step, 0);
    chk("rst_cnt", step_count, 0);
    chk("rst_halt", halted, 0);
    reset = 1'b0;
    wt(2);
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      wt(2);
    end
    step_btn = 1'b1;
    exp_q.push_back(cyc + 8);
    wt(15);
    chk("bounce_cnt", step_count, 1);
    chk("bounce_state", state, 0);
    step_btn = 1'b0;
    wt(15);
    chk("release_cnt", step_count, 1);
    rst_pulse();
    for (int i = 1; i <= 3; i++) begin
      press();
      chk("step_state", state, 0);
      chk("step_cnt", step_count, i);
    end
    rst_pulse();
    run_sw = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(cyc + 8 + 5 * k);
    wt(5);
    chk("run_state", state, 2);
    wt(22);
    run_sw = 1'b0;
    wt(15);
    chk("run_stop_state", state, 0);
    chk("run_cnt", step_count, 5);
    rst_pulse();
    run_sw = 1'b1;
    exp_q.push_back(cyc + 8);
    wt(10);
    run_sw = 1'b0;
    wt(10);
    chk("prio_cnt", step_count, 1);
    chk("prio_state", state, 0);
    rst_pulse();
    bp_en = 1'b1;
    bp_addr = 32'h0000_000C;
    run_sw = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(cyc + 8 + 5 * k);
    wt(25);
    chk("bp_state", state, 3);
    chk("bp_halted", halted, 1);
    chk("bp_cnt", step_count, 3);
    run_sw = 1'b0;
    wt(6);
    chk("halt_hold_lo", state, 3);
    run_sw = 1'b1;
    wt(6);
    chk("halt_hold_hi", state, 3);
    step_btn = 1'b1;
    exp_q.push_back(cyc + 8);
    wt(10);
    chk("bp_resume_state", state, 2);
    chk("bp_resume_halted", halted, 0);
    run_sw = 1'b0;
    step_btn = 1'b0;
    wt(12);
    chk("bp_resume_cnt", step_count, 4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_end_state", state, 0);
    bp_en = 1'b0;
    rst_pulse();
    for (int i = 1; i <= 17; i++) begin
      press();
      chk("wrap_cnt", step_count, i % 16);
    end
    rst_pulse();
    run_sw = 1'b1;
    exp_q.push_back(cyc + 8);
    exp_q.push_back(cyc + 13);
    wt(17);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_step", cpu_step, 0);
    chk("midrst_cnt", step_count, 0);
    chk("midrst_halt", halted, 0);
    wt(3);
    reset = 1'b0;
    exp_q.push_back(cyc + 8);
    wt(4);
    chk("rerun_state", state, 2);
    wt(5);
    run_sw = 1'b0;
    wt(10);
    chk("rerun_cnt", step_count, 1);
    chk("pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/step_run_controller.md
Name: step_run_controller

Overview:
Sequences the single-cycle processor by producing its clock-enable (cpu_step) from the board push button and a run switch. It replaces driving the processor clock directly from an undebounced button. Supports single-step, free-run at a divided rate, and halt on a PC breakpoint. It sits between the board I/O and the processor, alongside the 4-digit display multiplexer.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before the debounced button level changes
RUN_DIV, 25000000, clk cycles between cpu_step pulses in RUN (must be >= 2)
CNT_W, 16, width of step_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
step_btn  input  1  raw push button, asynchronous to clk
run_sw  input  1  raw run switch, asynchronous to clk
bp_en  input  1  breakpoint enable, static
bp_addr  input  32  breakpoint PC value, static
pc  input  32  current processor PC
cpu_step  output  1  one-cycle processor clock-enable pulse
step_count  output  CNT_W  number of cpu_step pulses issued, wrapping
halted  output  1  high while in HALT
state  output  2  IDLE=00, STEP=01, RUN=10, HALT=11

Behaviour:
- Reset (async, active-high): state=IDLE, cpu_step=0, step_count=0, halted=0. Synchronizer flops, debounce counter, debounced level, and rate counter are all cleared. A reset asserted mid-RUN or mid-STEP takes effect immediately, with no pulse completion.
- step_btn and run_sw each pass through a 2-flop synchronizer. run_sw is used synchronized only and is not debounced.
- Debounce: the counter resets whenever the synced button differs from its previous sample. When the synced button has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value.
- step_req is a 1-cycle pulse on a 0->1 transition of the debounced level. Falling transitions produce nothing.
- bp_hit = bp_en and (pc == bp_addr), evaluated combinationally.
- IDLE:
  - If run_sw is high -> RUN, and the rate counter starts from 0.
  - Else if step_req -> STEP.
  - If both occur in the same cycle, run_sw wins and step_req is dropped.
- STEP:
  - cpu_step=1 for exactly this cycle. Single steps ignore the breakpoint.
  - Next state is RUN if run_sw is high, else IDLE.
- RUN:
  - The rate counter increments each cycle and wraps from RUN_DIV-1 to 0.
  - At the cycle where the counter equals RUN_DIV-1: if bp_hit -> HALT with no pulse; else cpu_step=1.
  - The first pulse therefore occurs RUN_DIV cycles after entering RUN.
  - run_sw low -> IDLE and the rate counter clears. This takes priority over a terminal-count pulse in the same cycle.
  - step_req in RUN is ignored.
- HALT:
  - halted=1 and cpu_step=0.
  - step_req -> STEP, which steps past the breakpoint.
  - run_sw changes alone do not leave HALT.
- cpu_step is registered, so it is glitch-free and high for exactly one clk cycle.
- step_count increments by 1 on every cycle where cpu_step=1 and wraps from 2^CNT_W-1 to 0.
- Latency: button stable -> cpu_step is 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (STEP) cycles. The implementation must match this exactly, and the bench checks it.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=4):
- Bounce: toggle step_btn every 2 cycles for 20 cycles, then hold high -> exactly one cpu_step, 8 cycles after the final rise. step_count=1. Releasing the button produces no pulse.
- Single step x3: three clean presses (high 10, low 10) with run_sw=0 -> three 1-cycle cpu_step pulses, step_count=3, state returns to 00 each time.
- Run rate: run_sw=1 for 27 cycles after sync -> cpu_step pulses at cycles 5,10,15,20,25 after RUN entry, i.e. 5 pulses. Lowering run_sw -> state=00, no further pulses.
- Breakpoint: bp_en=1, bp_addr=0x0000000C; model pc += 4 on each cpu_step, starting from 0; run_sw=1 -> 3 pulses, then state=11, halted=1. One press -> one pulse (pc 0xC->0x10) and back to RUN, since run_sw is still high.
- Wrap: 17 single steps -> step_count reads 0xF after the 15th, 0x0 after the 16th, 0x1 after the 17th.
- Reset mid-run: assert reset asynchronously (between clk edges) in the cycle the rate counter reaches 4 -> immediate state=00, cpu_step=0, step_count=0. With run_sw still high after release, the first pulse comes 5 cycles after re-entering RUN.
